// File: rtl/hazard_mc.sv
// hazard_mc: pipeline hazard unit (forwarding, load-use stall, memory-wait stall/timeout); HAZARD_MC_PERF_EN enables perf counters.
// Latency: stall/flush/forward/timeout outputs are combinational from inputs and state (0 cycles); FSM and counters update on clk.
// Backpressure: MemReadyM low freezes F..M for up to MAX_WAIT cycles, then ErrTimeout pulses for one cycle and stalls release.
module hazard_mc #(
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 15,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic                  ResultSrcE_zero,
    input  logic                  PCSrcE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  MemReqM,
    input  logic                  MemReadyM,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  ErrTimeout,
    output logic [CNT_W-1:0]      PerfStallCnt,
    output logic [CNT_W-1:0]      PerfFlushCnt
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_WAIT - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_TIMEOUT = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [WCNT_W-1:0] r_wcnt;
    logic [WCNT_W-1:0] w_wcnt_nxt;
    logic              w_load_stall;
    logic              w_mem_stall;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;

    // Memory stage wins over writeback because it holds the younger result.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic [REG_ADDR_W-1:0] rd_w,
        input logic                  we_m,
        input logic                  we_w
    );
        if (src == '0)
            fwd_sel = 2'b00;
        else if (we_m && (rd_m == src))
            fwd_sel = 2'b10;
        else if (we_w && (rd_w == src))
            fwd_sel = 2'b01;
        else
            fwd_sel = 2'b00;
    endfunction

    assign w_fwd_a = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
    assign w_fwd_b = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);

    assign w_load_stall = ResultSrcE_zero && (RdE != '0) &&
                          ((RdE == Rs1D) || (RdE == Rs2D));

    // TIMEOUT drops the stall for one cycle so the pipeline can make progress.
    assign w_mem_stall = MemReqM && !MemReadyM && (r_state != S_TIMEOUT);

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        case (r_state)
            S_IDLE: begin
                if (w_mem_stall) begin
                    w_state_nxt = S_WAIT;
                    w_wcnt_nxt  = WCNT_W'(1);
                end
            end
            S_WAIT: begin
                if (MemReadyM || !MemReqM) begin
                    w_state_nxt = S_IDLE;
                    w_wcnt_nxt  = '0;
                end else if (r_wcnt == WCNT_LAST) begin
                    w_state_nxt = S_TIMEOUT;
                    w_wcnt_nxt  = '0;
                end else begin
                    w_wcnt_nxt = r_wcnt + WCNT_W'(1);
                end
            end
            S_TIMEOUT: begin
                w_state_nxt = S_IDLE;
                w_wcnt_nxt  = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_wcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    // A branch seen during a memory stall is held in frozen Execute and flushes on release.
    always_comb begin
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushW     = 1'b0;
        ForwardAE  = 2'b00;
        ForwardBE  = 2'b00;
        ErrTimeout = 1'b0;
        if (reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            ForwardAE  = w_fwd_a;
            ForwardBE  = w_fwd_b;
            ErrTimeout = (r_state == S_TIMEOUT);
            if (w_mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = w_load_stall;
                StallD = w_load_stall;
                FlushD = PCSrcE;
                FlushE = w_load_stall || PCSrcE;
            end
        end
    end

`ifdef HAZARD_MC_PERF_EN
    logic [CNT_W-1:0] r_perf_stall;
    logic [CNT_W-1:0] r_perf_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (StallF && !(&r_perf_stall))
                r_perf_stall <= r_perf_stall + CNT_W'(1);
            if (FlushE && !(&r_perf_flush))
                r_perf_flush <= r_perf_flush + CNT_W'(1);
        end
    end

    assign PerfStallCnt = r_perf_stall;
    assign PerfFlushCnt = r_perf_flush;
`else
    assign PerfStallCnt = '0;
    assign PerfFlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_mc.sv
// Bench for hazard_mc: table of combinational vectors plus directed multi-cycle stall/timeout/reset/perf sequences.
module tb_hazard_mc;

    localparam int AW = 5;
    localparam int MW = 4;
    localparam int CW = 2;

    // {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushW, FwdA, FwdB, Err}
    localparam logic [11:0] E_NONE = 12'b0000_000_00_00_0;
    localparam logic [11:0] E_MEM  = 12'b1111_001_00_00_0;
    localparam logic [11:0] E_TO   = 12'b0000_000_00_00_1;
    localparam logic [11:0] E_RST  = 12'b0000_111_00_00_0;
    localparam logic [11:0] E_LD   = 12'b1100_010_00_00_0;
    localparam logic [11:0] E_BR   = 12'b0000_110_00_00_0;

`ifdef HAZARD_MC_PERF_EN
    localparam logic [CW-1:0] PERF_SAT = 2'b11;
`else
    localparam logic [CW-1:0] PERF_SAT = 2'b00;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          ResultSrcE_zero, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ErrTimeout;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [CW-1:0] PerfStallCnt, PerfFlushCnt;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_mc #(.REG_ADDR_W(AW), .MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE_zero(ResultSrcE_zero), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ErrTimeout(ErrTimeout),
        .PerfStallCnt(PerfStallCnt), .PerfFlushCnt(PerfFlushCnt)
    );

    typedef struct {
        logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic          ld, pc, rwm, rww, mreq, mrdy;
        logic [11:0]   exp;
    } vec_t;

    function automatic vec_t mk(
        input logic [AW-1:0] rs1d, input logic [AW-1:0] rs2d, input logic [AW-1:0] rs1e,
        input logic [AW-1:0] rs2e, input logic [AW-1:0] rde, input logic [AW-1:0] rdm,
        input logic [AW-1:0] rdw, input logic ld, input logic pc, input logic rwm,
        input logic rww, input logic mreq, input logic mrdy, input logic [11:0] exp
    );
        vec_t v;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e; v.rde = rde;
        v.rdm = rdm; v.rdw = rdw; v.ld = ld; v.pc = pc; v.rwm = rwm; v.rww = rww;
        v.mreq = mreq; v.mrdy = mrdy; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e; RdE = v.rde;
        RdM = v.rdm; RdW = v.rdw; ResultSrcE_zero = v.ld; PCSrcE = v.pc;
        RegWriteM = v.rwm; RegWriteW = v.rww; MemReqM = v.mreq; MemReadyM = v.mrdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] got;
        #1;
        got = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE, ErrTimeout};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_cnt(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[15];
        vec_t z;
        z = mk(0,0,0,0,0,0,0, 0,0,0,0,0,0, E_NONE);
        //            rs1d rs2d rs1e rs2e rde rdm rdw  ld pc rwm rww mreq mrdy
        vecs[0]  = mk(0,  0,  5,  0,  0,  5,  5,   0, 0, 1,  1,  0,  0, 12'b0000_000_10_00_0);
        vecs[1]  = mk(0,  0,  5,  0,  0,  5,  5,   0, 0, 0,  1,  0,  0, 12'b0000_000_01_00_0);
        vecs[2]  = mk(0,  0,  0,  0,  0,  0,  0,   0, 0, 1,  1,  0,  0, 12'b0000_000_00_00_0);
        vecs[3]  = mk(0,  0,  0,  9,  0,  3,  9,   0, 0, 1,  1,  0,  0, 12'b0000_000_00_01_0);
        vecs[4]  = mk(0,  0,  3,  9,  0,  3,  9,   0, 0, 1,  1,  0,  0, 12'b0000_000_10_01_0);
        vecs[5]  = mk(0,  0,  4,  0,  0,  4,  6,   0, 0, 0,  1,  0,  0, 12'b0000_000_00_00_0);
        vecs[6]  = mk(0,  7,  0,  0,  7,  0,  0,   1, 0, 0,  0,  0,  0, E_LD);
        vecs[7]  = mk(12, 0,  0,  0,  12, 0,  0,   1, 0, 0,  0,  0,  0, E_LD);
        vecs[8]  = mk(0,  0,  0,  0,  0,  0,  0,   1, 0, 0,  0,  0,  0, E_NONE);
        vecs[9]  = mk(7,  0,  0,  0,  7,  0,  0,   0, 0, 0,  0,  0,  0, E_NONE);
        vecs[10] = mk(0,  0,  0,  0,  0,  0,  0,   0, 1, 0,  0,  0,  0, E_BR);
        vecs[11] = mk(0,  7,  0,  0,  7,  0,  0,   1, 1, 0,  0,  0,  0, 12'b1100_110_00_00_0);
        vecs[12] = mk(7,  0,  5,  0,  7,  5,  0,   1, 1, 1,  0,  1,  0, 12'b1111_001_10_00_0);
        vecs[13] = mk(0,  0,  0,  0,  0,  0,  0,   0, 0, 0,  0,  1,  1, E_NONE);
        vecs[14] = mk(0,  0,  2,  2,  0,  2,  2,   0, 0, 1,  1,  0,  1, 12'b0000_000_10_10_0);

        // Reset with hazards present on the inputs
        reset = 1'b1;
        drive(mk(7,0,5,0,7,5,5, 1,1,1,1,1,0, E_RST));
        check("reset_outputs", E_RST);
        tick();
        tick();
        check_cnt("reset_perf_stall", PerfStallCnt, 2'b00);
        check_cnt("reset_perf_flush", PerfFlushCnt, 2'b00);
        drive(z);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i]);
            check($sformatf("vec%0d", i), vecs[i].exp);
            tick();
        end
        drive(z);
        tick();

        // Memory wait of 3 cycles then ready
        MemReqM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("memwait_c%0d", i), E_MEM);
            tick();
        end
        MemReadyM = 1'b1;
        check("memwait_release", E_NONE);
        tick();
        drive(z);
        check("memwait_idle", E_NONE);
        tick();

        // Continuous stall with MAX_WAIT=4: 4 stall cycles, timeout pulse, then stall resumes
        MemReqM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("timeout_stall_c%0d", i), E_MEM);
            tick();
        end
        check("timeout_pulse", E_TO);
        tick();
        check("timeout_resume", E_MEM);
        tick();
        MemReadyM = 1'b1;
        check("timeout_release", E_NONE);
        tick();
        drive(z);
        tick();

        // Wait aborted by request dropping, then a full timeout must still take 4 cycles
        MemReqM = 1'b1;
        tick();
        tick();
        MemReqM = 1'b0;
        check("abort_idle", E_NONE);
        tick();
        MemReqM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("abort_stall_c%0d", i), E_MEM);
            tick();
        end
        check("abort_timeout", E_TO);
        tick();
        drive(z);
        tick();

        // Branch during a 2-cycle memory wait is deferred to the release cycle
        PCSrcE = 1'b1;
        MemReqM = 1'b1;
        check("defer_c0", E_MEM);
        tick();
        check("defer_c1", E_MEM);
        tick();
        MemReadyM = 1'b1;
        check("defer_release", E_BR);
        tick();
        drive(z);
        tick();

        // Reset while in WAIT and while in TIMEOUT
        MemReqM = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        Rs1E = 5; RdM = 5; RegWriteM = 1'b1;
        check("reset_in_wait", E_RST);
        tick();
        reset = 1'b0;
        Rs1E = 0; RdM = 0; RegWriteM = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("post_reset_stall_c%0d", i), E_MEM);
            tick();
        end
        reset = 1'b1;
        check("reset_in_timeout", E_RST);
        tick();
        reset = 1'b0;
        MemReqM = 1'b0;
        check("post_reset_idle", E_NONE);
        tick();
        check_cnt("perf_stall_cleared", PerfStallCnt, 2'b00);
        check_cnt("perf_flush_cleared", PerfFlushCnt, 2'b00);

        // Load-use stalls feed the perf counters (saturate at 3 with CNT_W=2)
        ResultSrcE_zero = 1'b1; RdE = 7; Rs2D = 7;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("loaduse_c%0d", i), E_LD);
            tick();
        end
        drive(z);
        check("loaduse_done", E_NONE);
        check_cnt("perf_stall_3", PerfStallCnt, PERF_SAT);
        check_cnt("perf_flush_3", PerfFlushCnt, PERF_SAT);
        ResultSrcE_zero = 1'b1; RdE = 7; Rs2D = 7;
        tick();
        tick();
        drive(z);
        #1;
        check_cnt("perf_stall_sat", PerfStallCnt, PERF_SAT);
        check_cnt("perf_flush_sat", PerfFlushCnt, PERF_SAT);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
